gcd: RTL and testbench



---
 rtl/gcd_pkg.sv | 14 +
 rtl/gcd_datapath.sv | 64 ++++++
 rtl/gcd.sv | 104 ++++++++++
 tb/tb_gcd.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the subtractive-Euclid GCD engine.
//   state_t   - controller states (IDLE, CALC, DONE)
//   GCD_WIDTH - default operand/result width
package gcd_pkg;

  localparam int GCD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_datapath.sv
// gcd_datapath: A/B operand registers, comparator and one shared subtractor.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset (clears A and B)
//   load         - capture in1/in2 into A/B
//   step         - replace the larger operand by (larger - smaller)
//   in1, in2     - operands sampled on load
//   finish       - iteration has reached a terminal condition
//   result       - GCD value valid when finish is high
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             finish,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             a_zero;
  logic             b_zero;
  logic             a_eq_b;
  logic             a_gt_b;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic [WIDTH-1:0] diff;

  assign a_zero = (a_reg == '0);
  assign b_zero = (b_reg == '0);
  assign a_eq_b = (a_reg == b_reg);
  assign a_gt_b = (a_reg > b_reg);

  // Steer the larger operand into the minuend so the single subtractor
  // can never underflow.
  assign minuend    = a_gt_b ? a_reg : b_reg;
  assign subtrahend = a_gt_b ? b_reg : a_reg;
  assign diff       = minuend - subtrahend;

  assign finish = b_zero | a_zero | a_eq_b;

  // Priority: B==0 -> A, A==0 -> B, A==B -> A. Only the A==0 (B nonzero)
  // case selects B; gcd(0,0) falls into the first branch and yields 0.
  assign result = (!b_zero && a_zero) ? b_reg : a_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (load) begin
      a_reg <= in1;
      b_reg <= in2;
    end else if (step) begin
      if (a_gt_b) a_reg <= diff;
      else        b_reg <= diff;
    end
  end

endmodule

// File: rtl/gcd.sv
// gcd: iterative subtractive-Euclid GCD engine, one subtraction per clock.
// Ports:
//   clk      - clock, all state on rising edge
//   rst      - asynchronous active-low reset
//   in1, in2 - operands, sampled when go is accepted (IDLE or DONE)
//   go       - start request, level-sampled
//   out      - registered GCD result, held until the next result is written
//   done     - result-valid level (high in DONE)
//   steps    - subtraction count of the current/last run
//              (present only when GCD_STEP_COUNT_EN is defined)
// Build option: `define GCD_STEP_COUNT_EN to add the steps counter/port.
module gcd
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             go,
  output logic [WIDTH-1:0] out,
  output logic             done
`ifdef GCD_STEP_COUNT_EN
  ,
  output logic [WIDTH-1:0] steps
`endif
);

  state_t           state_reg;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             capture;
  logic             finish;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] out_reg;

  gcd_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .in1    (in1),
    .in2    (in2),
    .finish (finish),
    .result (result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (go) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        // go is deliberately ignored here; operands stay as loaded.
        if (finish) begin
          capture    = 1'b1;
          state_next = DONE;
        end else begin
          step = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         out_reg <= '0;
    else if (capture) out_reg <= result;
  end

  assign out  = out_reg;
  // done is decoded from the state register, so it moves on the same edge
  // as out and drops on the edge that accepts a new go.
  assign done = (state_reg == DONE);

`ifdef GCD_STEP_COUNT_EN
  logic [WIDTH-1:0] steps_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      steps_reg <= '0;
    else if (load) steps_reg <= '0;
    else if (step) steps_reg <= steps_reg + 1'b1;
  end

  assign steps = steps_reg;
`endif

endmodule

// File: tb/tb_gcd.sv
// tb_gcd: directed self-checking bench for the gcd engine (WIDTH=32).
module tb_gcd;

  localparam int W = 32;
  localparam int BUDGET = 20000;

  logic         clk;
  logic         rst;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         go;
  logic [W-1:0] out;
  logic         done;
`ifdef GCD_STEP_COUNT_EN
  logic [W-1:0] steps;
`endif

  int total;
  int bad;

  gcd #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .in1  (in1),
    .in2  (in2),
    .go   (go),
    .out  (out),
    .done (done)
`ifdef GCD_STEP_COUNT_EN
    ,
    .steps(steps)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Drive operands with go for exactly one accepting edge (edge 1).
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    in1 = a;
    in2 = b;
    go  = 1'b1;
    @(posedge clk);
    #1;
    go  = 1'b0;
  endtask

  // Starting just after some edge n, wait for done; returns edge index.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < BUDGET) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp, input int exp_edges);
    int n;
    start(a, b);
    check({tag, "_done_low_after_go"}, {31'd0, done}, 0);
    wait_done(1, n);
    check({tag, "_done"}, {31'd0, done}, 1);
    check({tag, "_out"}, out, exp);
    if (exp_edges > 0) check({tag, "_edges"}, n, exp_edges);
  endtask

  initial begin
    int n;
    logic [W-1:0] held;
    total = 0;
    bad   = 0;
    rst = 1'b0;
    go  = 1'b0;
    in1 = '0;
    in2 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, 0);
    check("reset_done", {31'd0, done}, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_done", {31'd0, done}, 0);

    run("g45_90", 45, 90, 45, 3);

    // Abort a running computation with reset asserted between edges.
    start(48123, 628163);
    repeat (5) @(posedge clk);
    #1;
    check("calc_done_low", {31'd0, done}, 0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_out", out, 0);
    check("async_rst_done", {31'd0, done}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run("g45_90_after_rst", 45, 90, 45, 3);

    run("g48123_628163", 48123, 628163, 1, 0);
    held = out;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (out !== held || done !== 1'b1) begin
        check("hold_out", out, held);
        check("hold_done", {31'd0, done}, 1);
      end
    end
    check("hold_out_final", out, 1);
    check("hold_done_final", {31'd0, done}, 1);

    run("g2000_10000", 2000, 10000, 2000, 6);
    run("g35_49", 35, 49, 7, 6);
`ifdef GCD_STEP_COUNT_EN
    check("steps_35_49", steps, 4);
`endif
    run("g0_12", 0, 12, 12, 2);
    run("g12_0", 12, 0, 12, 2);
    run("g0_0", 0, 0, 0, 2);

    // go and operands disturbed during CALC must be ignored.
    start(35, 49);
    in1 = 1;
    in2 = 1;
    go  = 1'b1;
    @(posedge clk);
    #1;
    go  = 1'b0;
    in1 = 99;
    in2 = 33;
    wait_done(2, n);
    check("ignore_go_out", out, 7);
    check("ignore_go_edges", n, 6);

    // Back-to-back: go held in DONE relaunches; out holds until rewritten.
    in1 = 12;
    in2 = 18;
    go  = 1'b1;
    @(posedge clk);
    #1;
    go  = 1'b0;
    check("b2b_done_drop", {31'd0, done}, 0);
    check("b2b_out_held", out, 7);
    wait_done(1, n);
    check("b2b_out", out, 6);
    check("b2b_edges", n, 4);
`ifdef GCD_STEP_COUNT_EN
    check("b2b_steps", steps, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
